// File: rtl/addsub_sat_multicycle.sv
// Chunked signed add/subtract with selectable overflow policy.
// Valid/ready on both sides plus a sticky overflow status bit.
module addsub_sat_multicycle #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] part;
   logic             carry;
   logic             a_msb;
   logic             b_msb;
   logic [1:0]       mode_r;
   logic [KW-1:0]    k;

   logic             accept;
   logic             last;
   logic             deliver;
   logic [CHUNK:0]   csum;
   logic [WIDTH-1:0] raw;
   logic             ovf;
   logic [WIDTH-1:0] pol;
   logic             in_ready_n;
   logic             out_valid_n;

   assign accept  = (state == IDLE) && in_valid;
   assign last    = (k == KW'(NCH - 1));
   assign deliver = (state == DONE) && out_ready;

   // Operands shift right one chunk per cycle; result fills from the top.
   assign csum = {1'b0, a_sh[CHUNK-1:0]}
               + {1'b0, b_sh[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, carry};
   assign raw  = (part >> CHUNK)
               | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
   assign ovf  = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

   always_comb begin
      pol = raw;
      unique case (1'b1)
         (mode_r == 2'b01): pol = ovf ? '0 : raw;
         (mode_r == 2'b10): begin
            if (ovf)
               pol = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
         end
         default: pol = raw;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid) state_n = CALC;
         CALC:    if (last) state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      in_ready_n  = (state_n == IDLE);
      out_valid_n = (state_n == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= in_ready_n;
         out_valid <= out_valid_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         part     <= '0;
         carry    <= 1'b0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         mode_r   <= 2'b00;
         k        <= '0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_sh   <= a;
         b_sh   <= b ^ {WIDTH{sub}};
         part   <= '0;
         carry  <= sub;
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1] ^ sub;
         mode_r <= mode;
         k      <= '0;
      end else if (state == CALC) begin
         a_sh  <= a_sh >> CHUNK;
         b_sh  <= b_sh >> CHUNK;
         part  <= raw;
         carry <= csum[CHUNK];
         k     <= last ? '0 : k + KW'(1);
         if (last) begin
            sum      <= pol;
            c_out    <= csum[CHUNK];
            overflow <= ovf;
         end
      end
   end

   // A coincident delivered overflow beats a clear request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_sticky <= 1'b0;
      else if (deliver && overflow)
         ovf_sticky <= 1'b1;
      else if (ovf_clr)
         ovf_sticky <= 1'b0;
   end

endmodule
